// File: rtl/uart_pkg.sv
// uart_pkg: shared UART parity codes, transmitter FSM states and baud divider helper.
// Used by uart_tx_q and intended for the matching receiver.
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} uart_tx_st_e;
  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with extra-MSB pointers.
// Ports: clk, rst (sync, active high), push/wdata, pop/rdata (head, show-ahead),
//        full, empty, level (occupancy, $clog2(DEPTH)+1 bits).
// Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop) rptr <= rptr + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk) if (do_push && !rst) mem[wptr[AW-1:0]] <= wdata;
  assign rdata = mem[rptr[AW-1:0]];
  assign level = wptr - rptr;
  // Same slot index but different lap bit means the writer is a full lap ahead.
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = wptr == rptr;
endmodule

// File: rtl/uart_tx_q.sv
// uart_tx_q: queued UART transmitter, configurable data bits, parity and stop bits.
// Ports: clk, rst (sync, active high), tdata/tvld/trdy push handshake into the FIFO,
//        txd serial line (idle high), busy (frame on the line), level (FIFO occupancy).
// Queued words are sent back-to-back: the end of a stop bit pops the next word directly.
module uart_tx_q
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATIO = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tdata,
  input  logic                          tvld,
  output logic                          trdy,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int DIV = baud_div(CLK_FREQ, BAUD_RATIO);
  localparam int CW  = DIV < 2 ? 1 : $clog2(DIV);
  localparam int BW  = $clog2(DATA_BITS);
  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_q: CLK_FREQ/BAUD_RATIO must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_tx_q: DATA_BITS must be 5..9");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_par
    $error("uart_tx_q: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_q: STOP_BITS must be 1 or 2");
  end
  uart_tx_st_e st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bidx, bidx_n;
  logic [DATA_BITS-1:0] sh, sh_n, head;
  logic par, par_n, txd_n, pop, tick, full, empty;
  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(tvld),
    .wdata(tdata),
    .pop(pop),
    .rdata(head),
    .full(full),
    .empty(empty),
    .level(level)
  );
  assign trdy = ~full;
  assign tick = cnt == CW'(DIV - 1);
  always_comb begin
    st_n   = st;
    cnt_n  = (st == IDLE || tick) ? '0 : cnt + CW'(1);
    bidx_n = bidx;
    sh_n   = sh;
    par_n  = par;
    txd_n  = txd;
    pop    = 1'b0;
    case (st)
      IDLE: if (!empty) begin
        pop   = 1'b1;
        st_n  = START;
        txd_n = 1'b0;
      end
      START: if (tick) begin
        st_n   = DATA;
        txd_n  = sh[0];
        sh_n   = sh >> 1;
        bidx_n = '0;
      end
      DATA: if (tick) begin
        if (bidx != BW'(DATA_BITS - 1)) begin
          bidx_n = bidx + BW'(1);
          txd_n  = sh[0];
          sh_n   = sh >> 1;
        end else if (PARITY != PAR_NONE) begin
          st_n  = PAR;
          txd_n = par;
        end else begin
          st_n   = STOP;
          txd_n  = 1'b1;
          bidx_n = '0;
        end
      end
      PAR: if (tick) begin
        st_n   = STOP;
        txd_n  = 1'b1;
        bidx_n = '0;
      end
      STOP: if (tick) begin
        if (bidx != BW'(STOP_BITS - 1)) bidx_n = bidx + BW'(1);
        else if (!empty) begin
          pop   = 1'b1;
          st_n  = START;
          txd_n = 1'b0;
        end else st_n = IDLE;
      end
      default: st_n = IDLE;
    endcase
    // Parity is taken from the whole word at pop time, before shifting destroys it.
    if (pop) begin
      sh_n  = head;
      par_n = (PARITY == PAR_ODD) ? ~^head : ^head;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= IDLE;
      cnt  <= '0;
      bidx <= '0;
      sh   <= '0;
      par  <= 1'b0;
      txd  <= 1'b1;
      busy <= 1'b0;
    end else begin
      st   <= st_n;
      cnt  <= cnt_n;
      bidx <= bidx_n;
      sh   <= sh_n;
      par  <= par_n;
      txd  <= txd_n;
      busy <= st_n != IDLE;
    end
  end
endmodule

// File: tb/tb_uart_tx_q.sv
// tb_uart_tx_q: four uart_tx_q configurations checked every cycle against a frame-level queue model.
module tb_uart_tx_q;
  logic tb_clk = 1'b0;
  logic rst = 1'b1;
  logic tvld [4];
  logic [8:0] tdata [4];
  logic trdy [4], txd [4], busy [4];
  logic [2:0] level [4];
  int checks = 0;
  int errors = 0;
  int bcnt [4] = '{default: 0};
  int rise [4] = '{default: 0};
  logic pb [4] = '{default: 1'b0};
  always #5 tb_clk = ~tb_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic fbit(input int nb, input int pr, input int w, input int idx);
    logic [31:0] v;
    v = w;
    if (idx == 0) return 1'b0;
    if (idx <= nb) return v[idx-1];
    if (pr != 0 && idx == nb + 1) return pr == 1 ? ~^v : ^v;
    return 1'b1;
  endfunction
  // 0: 8N1 DIV 434, 1: 7E1 DIV 4, 2: 7O1 DIV 4, 3: 8N2 DIV 434
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int CF = (g == 0 || g == 3) ? 50_000_000 : 400;
    localparam int BR = (g == 0 || g == 3) ? 115200 : 100;
    localparam int NB = (g == 1 || g == 2) ? 7 : 8;
    localparam int PR = g == 1 ? 2 : g == 2 ? 1 : 0;
    localparam int SB = g == 3 ? 2 : 1;
    localparam int DV = CF / BR;
    localparam int FL = (1 + NB + (PR != 0 ? 1 : 0) + SB) * DV;
    uart_tx_q #(
      .CLK_FREQ(CF), .BAUD_RATIO(BR), .DATA_BITS(NB),
      .PARITY(PR), .STOP_BITS(SB), .FIFO_DEPTH(4)
    ) u_dut (
      .clk(tb_clk),
      .rst(rst),
      .tdata(tdata[g][NB-1:0]),
      .tvld(tvld[g]),
      .trdy(trdy[g]),
      .txd(txd[g]),
      .busy(busy[g]),
      .level(level[g])
    );
    int q [$];
    int t = 0;
    int cur = 0;
    bit act = 1'b0;
    initial forever begin
      bit push, ending;
      @(posedge tb_clk);
      if (rst) begin
        q.delete();
        act = 1'b0;
        t = 0;
      end else begin
        push = tvld[g] && q.size() < 4;
        ending = act && t == FL - 1;
        t++;
        if ((!act || ending) && q.size() > 0) begin
          cur = q.pop_front();
          act = 1'b1;
          t = 0;
        end else if (ending) act = 1'b0;
        if (push) q.push_back(int'(tdata[g]) & ((1 << NB) - 1));
      end
    end
    initial forever begin
      @(negedge tb_clk);
      chk($sformatf("txd%0d", g), txd[g], act ? fbit(NB, PR, cur, t / DV) : 1'b1);
      chk($sformatf("busy%0d", g), busy[g], act);
      chk($sformatf("level%0d", g), level[g], q.size());
      chk($sformatf("trdy%0d", g), trdy[g], q.size() < 4);
    end
  end
  initial forever begin
    @(negedge tb_clk);
    for (int i = 0; i < 4; i++) begin
      if (busy[i]) bcnt[i]++;
      if (busy[i] && !pb[i]) rise[i]++;
      pb[i] = busy[i];
    end
  end
  initial begin
    logic [8:0] hello [6];
    int b0 [4], r0 [4], idx [4];
    int a6;
    bit done;
    hello = '{9'h68, 9'h65, 9'h6c, 9'h6c, 9'h6f, 9'h21};
    tvld = '{default: 1'b0};
    tdata = '{default: 9'h0};
    repeat (2) @(negedge tb_clk);
    chk("rst_txd", txd[0], 1);
    chk("rst_busy", busy[0], 0);
    chk("rst_level", level[0], 0);
    chk("rst_trdy", trdy[0], 1);
    rst = 1'b0;
    @(negedge tb_clk);
    b0 = bcnt;
    tvld = '{default: 1'b1};
    tdata = '{9'h68, 9'h55, 9'h55, 9'h1ff};
    @(negedge tb_clk);
    tvld = '{default: 1'b0};
    chk("lat_level", level[0], 1);
    chk("lat_busy", busy[0], 0);
    chk("lat_txd", txd[0], 1);
    for (int j = 0; j < 5000; j++) begin
      @(negedge tb_clk);
      if (j == 0) begin
        chk("start_txd", txd[0], 0);
        chk("start_busy", busy[0], 1);
      end
      if (j == 33) begin
        chk("par_even", txd[1], 0);
        chk("par_odd", txd[2], 1);
      end
      if (j == 1735) chk("bit2_low", txd[0], 0);
      if (j == 1736) chk("bit3_high", txd[0], 1);
    end
    chk("busy_len_8n1", bcnt[0] - b0[0], 4340);
    chk("busy_len_7e1", bcnt[1] - b0[1], 40);
    chk("busy_len_7o1", bcnt[2] - b0[2], 40);
    chk("busy_len_8n2", bcnt[3] - b0[3], 4774);
    b0 = bcnt;
    r0 = rise;
    idx = '{default: 0};
    a6 = 0;
    done = 1'b0;
    for (int c = 0; c < 10000 && !done; c++) begin
      @(negedge tb_clk);
      done = 1'b1;
      for (int i = 0; i < 4; i++) if (idx[i] < 6) done = 1'b0;
      if (c < 6) a6 += int'(trdy[0]);
      if (c == 5) chk("burst_trdy6", trdy[0], 0);
      for (int i = 0; i < 4; i++) begin
        tvld[i] = idx[i] < 6;
        if (idx[i] < 6) begin
          tdata[i] = hello[idx[i]];
          if (trdy[i]) idx[i]++;
        end
      end
    end
    chk("burst_sent", done, 1);
    chk("burst_accept5", a6, 5);
    repeat (25000) @(negedge tb_clk);
    chk("burst_len0", bcnt[0] - b0[0], 26040);
    chk("burst_gap0", rise[0] - r0[0], 1);
    chk("burst_len1", bcnt[1] - b0[1], 240);
    chk("burst_gap1", rise[1] - r0[1], 1);
    chk("burst_len3", bcnt[3] - b0[3], 28644);
    chk("burst_gap3", rise[3] - r0[3], 1);
    for (int c = 0; c < 8; c++) begin
      @(negedge tb_clk);
      for (int i = 0; i < 4; i++) begin
        tvld[i] = 1'b1;
        tdata[i] = 9'($urandom);
      end
    end
    @(negedge tb_clk);
    tvld = '{default: 1'b0};
    chk("fill_level", level[0], 4);
    chk("fill_trdy", trdy[0], 0);
    repeat (5208) @(negedge tb_clk);
    chk("pre_rst_level", level[0], 3);
    chk("pre_rst_busy", busy[0], 1);
    rst = 1'b1;
    @(negedge tb_clk);
    rst = 1'b0;
    chk("mid_rst_txd", txd[0], 1);
    chk("mid_rst_level", level[0], 0);
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_level3", level[3], 0);
    r0 = rise;
    repeat (5000) @(negedge tb_clk);
    chk("no_resend0", rise[0] - r0[0], 0);
    chk("no_resend3", rise[3] - r0[3], 0);
    for (int c = 0; c < 3000; c++) begin
      @(negedge tb_clk);
      rst = $urandom_range(0, 499) == 0;
      for (int i = 1; i < 3; i++) begin
        tvld[i] = $urandom_range(0, 2) == 0;
        tdata[i] = 9'($urandom);
      end
    end
    @(negedge tb_clk);
    rst = 1'b0;
    tvld = '{default: 1'b0};
    repeat (300) @(negedge tb_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_q.md
# uart_tx_q

Parametrised, queued UART transmitter. It is the next generation of the single-byte `uart_tx`, with configurable data width, parity and stop bits, and an internal TX FIFO so software or a bench can push bursts without waiting per byte. It sits between the core's UART MMIO register (or a testbench driver) and the `txd` pin. It streams queued words back-to-back, with no idle gap between frames.

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD_RATIO`, 115200: baud rate. `DIV = CLK_FREQ/BAUD_RATIO` (truncated; 434 at defaults). `DIV < 2` is an elaboration error.
- `DATA_BITS`, 8: data bits per frame, legal range 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even. 3 is an elaboration error.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: number of queued words, power of two, at least 2.
- `clk  in  1`: the single clock.
- `rst  in  1`: synchronous, active-high reset.
- `tdata  in  DATA_BITS`: word to send.
- `tvld  in  1`: `tdata` is valid.
- `trdy  out  1`: the FIFO can accept a word.
- `txd  out  1`: serial output, idle high.
- `busy  out  1`: a frame is on the line.
- `level  out  $clog2(FIFO_DEPTH)+1`: FIFO occupancy.

## Operation
- Push handshake:
  - A word is accepted on a rising edge where `tvld & trdy`.
  - `trdy = (level < FIFO_DEPTH)`. There is no full-FIFO pass-through.
  - `tvld` while `trdy=0` is ignored; no state changes.
- FSM states: IDLE, START, DATA, PAR, STOP.
- Each state is held for exactly `DIV` cycles per bit, counted by the baud counter `0..DIV-1`. The next bit begins on the edge where the count equals `DIV-1`.
- IDLE:
  - If `level != 0`, pop the FIFO head into the shift register, drive `txd <= 0`, and go to START.
- START → DATA:
  - Data is sent LSB first, `DATA_BITS` bits.
- DATA → PAR if `PARITY != 0`, else → STOP.
- Parity bit value:
  - Odd: total number of ones across data and parity is odd.
  - Even: total number of ones is even.
- STOP:
  - `txd = 1` for `STOP_BITS*DIV` cycles.
  - At the end of STOP, if `level != 0`, pop and enter START on the same edge (no idle cycle). Otherwise go to IDLE.
- Simultaneous push and pop on one edge: `level` is unchanged and both operations take effect.
- Frame length: `(1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * DIV` cycles.
- `busy` is 1 in every state except IDLE.

## Timing
- Reset values, one edge after `rst=1`:
  - `txd=1`, `busy=0`, `level=0`, `trdy=1`.
  - FSM = IDLE, baud counter = 0, FIFO pointers = 0.
- While `rst=1`, pushes are ignored.
- Reset mid-frame: the frame is abandoned, `txd` returns high on the next edge, and the FIFO is flushed.
- `txd` and `busy` are registered outputs. `trdy` and `level` come from registered pointers.
- Latency: a word pushed at edge k into an empty FIFO with FSM IDLE gives `level=1` after edge k. `txd` falls after edge k+1, and `busy=1` after edge k+1.
- FIFO pointers are `$clog2(FIFO_DEPTH)+1` bits wide. Full is signalled by the MSB differing with the remaining bits equal. Pointers wrap naturally.

## Structure
- Package `uart_pkg` holds:
  - the parity mode constants `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`;
  - the FSM state enum `uart_tx_st_e`;
  - the function `baud_div(clk_freq, baud)`.
- `uart_pkg` is shared with the future `uart_rx_q`.
- Sub-module `sync_fifo` is parametrised by `WIDTH` and `DEPTH`, uses the same `clk`/`rst`, and provides push/pop/level. It will be reused by the RX path.
- FSM, baud counter and shift register live in `uart_tx_q`.

## Test plan
- Defaults (8N1, `DIV=434`), push 0x68 ("h") at edge k:
  - `txd` low for cycles k+1..k+434.
  - Data bits 0,0,0,1,0,1,1,0, then stop high.
  - `busy` high for exactly 4340 cycles.
- Burst of "hello!" (6 bytes) on consecutive cycles, `FIFO_DEPTH=4`:
  - First 5 bytes accepted; `trdy=0` on the 6th until the next frame start pops.
  - All 6 frames are contiguous with no idle high cycle between them.
- `DATA_BITS=7`, `PARITY=2`, send 0x55: parity bit 0. With `PARITY=1`: parity bit 1. Frame is 10·DIV cycles.
- `STOP_BITS=2`, send 0xFF: stop high for 868 cycles, then the next queued frame starts immediately.
- Fill the FIFO with `tvld` held high and no pop possible (first frame in progress): `level` saturates at 4 and extra words are dropped. The delivered sequence matches the first 5 accepted words.
- Assert `rst` for 1 cycle in the middle of DATA with 3 words queued:
  - `txd=1`, `level=0`, `busy=0` on the next edge.
  - No further frames are sent.
